// File: rtl/uart_pkt_tx_if.sv
// Byte-framer bus bundle: word input handshake plus the UART TX byte handshake.
// Latency: n/a (wires only).
// Backpressure: in_ready from the framer; the UART side paces itself via tx_busy.
// Ports: in_data/in_valid/in_ready (word in), tx_data/tx_start/tx_busy (UART byte side),
//        fifo_level/active (status). slave = the framer, master = its environment.
interface uart_pkt_tx_if #(
  parameter int NBYTES = 4,
  parameter int DEPTH  = 4
);
  logic [8*NBYTES-1:0]    in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             tx_data;
  logic                   tx_start;
  logic                   tx_busy;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   active;

  modport slave (
    input  in_data, in_valid, tx_busy,
    output in_ready, tx_data, tx_start, fifo_level, active
  );

  modport master (
    output in_data, in_valid, tx_busy,
    input  in_ready, tx_data, tx_start, fifo_level, active
  );
endinterface

// File: rtl/uart_pkt_tx.sv
// Packet framer: buffers result words, sends each as HDR, NBYTES data bytes LSB first, 8-bit sum.
// Latency: word pushed into empty FIFO at edge N is popped at N+1; header tx_start high N+1..N+2.
// Backpressure: in_ready drops when the FIFO holds DEPTH words; bytes wait for tx_busy to fall.
// Ports: clk, rst (async, active-high); bus (slave modport of uart_pkt_tx_if):
//   in_data/in_valid/in_ready word input, tx_data/tx_start/tx_busy UART byte handshake,
//   fifo_level buffered word count, active high while a packet is in flight.
module uart_pkt_tx #(
  parameter int          NBYTES = 4,
  parameter int          DEPTH  = 4,
  parameter logic [7:0]  HDR    = 8'hA5
) (
  input  logic         clk,
  input  logic         rst,
  uart_pkt_tx_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = 8 * NBYTES;
  // idx counts 0 (header) .. NBYTES+1 (checksum)
  localparam int IW = $clog2(NBYTES + 2);
  localparam logic [IW-1:0] LAST_DATA = IW'(NBYTES);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NBYTES + 1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------------
  logic [WW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  // Full blocks a push even when a pop happens in the same cycle.
  assign bus.in_ready   = (count != FULL);
  assign push           = bus.in_valid && bus.in_ready;
  assign pop            = (state_q == IDLE) && (count != '0);
  assign bus.fifo_level = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by overflow.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  // ---------------------------------------------------------------------------
  // Framer FSM and datapath
  // ---------------------------------------------------------------------------
  logic [WW-1:0] sr_q, sr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count != '0) state_d = START;
      START:   state_d = WAIT_HI;
      // A busy already high on entry is taken as the rise.
      WAIT_HI: if (bus.tx_busy) state_d = WAIT_LO;
      WAIT_LO: if (!bus.tx_busy) state_d = (idx_q == LAST_IDX) ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; tx_start is only ever raised on entry to START.
  always_comb begin
    sr_d       = sr_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          sr_d       = mem[rd_ptr];
          idx_d      = '0;
          csum_d     = '0;
          tx_data_d  = HDR;
          tx_start_d = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!bus.tx_busy && (idx_q != LAST_IDX)) begin
          idx_d      = idx_q + 1'b1;
          tx_start_d = 1'b1;
          if (idx_q == LAST_DATA) begin
            // All data bytes are out; the sum (header excluded) goes last.
            tx_data_d = csum_q;
          end else begin
            tx_data_d = sr_q[7:0];
            sr_d      = sr_q >> 8;
            csum_d    = csum_q + sr_q[7:0];
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset abandons any partial packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q       <= '0;
      idx_q      <= '0;
      csum_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.active   = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_start_only_in_start: assert property (@(posedge clk) disable iff (rst)
    bus.tx_start |-> (state_q == START));
  a_start_state_has_start: assert property (@(posedge clk) disable iff (rst)
    (state_q == START) |-> bus.tx_start);
  a_level_bound: assert property (@(posedge clk) disable iff (rst)
    count <= FULL);

endmodule

// File: tb/tb_uart_pkt_tx.sv
module tb_uart_pkt_tx;
  localparam int NB = 4;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_pkt_tx_if #(.NBYTES(NB), .DEPTH(DP)) bus ();
  uart_pkt_tx #(.NBYTES(NB), .DEPTH(DP), .HDR(8'hA5)) dut (.clk(clk), .rst(rst), .bus(bus));

  uart_pkt_tx_if #(.NBYTES(1), .DEPTH(2)) bus1 ();
  uart_pkt_tx #(.NBYTES(1), .DEPTH(2), .HDR(8'h5A)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  uart_pkt_tx_if #(.NBYTES(8), .DEPTH(4)) bus8 ();
  uart_pkt_tx #(.NBYTES(8), .DEPTH(4), .HDR(8'hA5)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp1_q [$];
  logic [7:0] exp8_q [$];
  int busy_len = 260;
  bit stall = 1'b0;
  int busy_cnt = 0;
  int starts = 0;
  int n1 = 0;
  int n8 = 0;

  // Stall test words and hand-computed checksums
  logic [31:0] w3 [6] = '{32'h11223344, 32'h01010101, 32'h80808080,
                          32'hDEADBEEF, 32'h0000FF01, 32'h7F000001};
  logic [7:0]  c3 [6] = '{8'hAA, 8'h04, 8'h00, 8'h38, 8'h00, 8'h80};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] w, input logic [7:0] cs);
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
    exp_q.push_back(cs);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_word(input logic [31:0] w, input logic [7:0] cs);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      tests++; fails++;
      $display("FAIL push_timeout: in_ready=%0d, expected 1", bus.in_ready);
    end else begin
      exp_push(w, cs);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((bus.active || bus.fifo_level != 0) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30000) begin
      tests++; fails++;
      $display("FAIL %s: active=%0d level=%0d after timeout, expected 0 0", name, bus.active, bus.fifo_level);
    end
  endtask

  // UART model + byte monitor for the main DUT
  task automatic tx_main();
    logic prev_start = 1'b0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.tx_busy = 1'b0;
        busy_cnt    = 0;
        prev_start  = 1'b0;
      end else begin
        if (bus.tx_start) begin
          check("start_width", prev_start, 0);
          check("start_while_busy", bus.tx_busy, 0);
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL tx_byte: got %0h, expected no byte", bus.tx_data);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", bus.tx_data, e);
          end
          starts++;
          bus.tx_busy = 1'b1;
          busy_cnt    = busy_len;
        end else if (bus.tx_busy && !stall) begin
          busy_cnt--;
          if (busy_cnt <= 0) bus.tx_busy = 1'b0;
        end
        prev_start = bus.tx_start;
      end
    end
  endtask

  // UART models + byte monitors for the parameter-sweep instances
  task automatic tx_sweep();
    int c1 = 0;
    int c8 = 0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus1.tx_busy = 1'b0; c1 = 0;
        bus8.tx_busy = 1'b0; c8 = 0;
      end else begin
        if (bus1.tx_start) begin
          if (exp1_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL tx1_byte: got %0h, expected no byte", bus1.tx_data);
          end else begin
            e = exp1_q.pop_front();
            check("tx1_byte", bus1.tx_data, e);
          end
          n1++;
          bus1.tx_busy = 1'b1; c1 = 3;
        end else if (c1 > 0) begin
          c1--;
          if (c1 == 0) bus1.tx_busy = 1'b0;
        end
        if (bus8.tx_start) begin
          if (exp8_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL tx8_byte: got %0h, expected no byte", bus8.tx_data);
          end else begin
            e = exp8_q.pop_front();
            check("tx8_byte", bus8.tx_data, e);
          end
          n8++;
          bus8.tx_busy = 1'b1; c8 = 3;
        end else if (c8 > 0) begin
          c8--;
          if (c8 == 0) bus8.tx_busy = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int base;
    int k;
    int n;
    rst = 1'b1;
    bus.in_valid  = 1'b0; bus.in_data  = '0; bus.tx_busy  = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.tx_busy = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.tx_busy = 1'b0;
    fork
      tx_main();
      tx_sweep();
    join_none

    // Reset state
    #1;
    check("rst_level", bus.fifo_level, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_active", bus.active, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single word, long UART frames, then two words queued behind it
    busy_len = 260;
    base = starts;
    push_word(32'h12345678, 8'h14);
    check("lat_level", bus.fifo_level, 1);
    check("lat_no_start", bus.tx_start, 0);
    check("lat_active_lo", bus.active, 0);
    @(negedge clk);
    check("lat_start", bus.tx_start, 1);
    check("lat_hdr", bus.tx_data, 8'hA5);
    check("lat_popped", bus.fifo_level, 0);
    check("lat_active_hi", bus.active, 1);
    push_word(32'h00000000, 8'h00);
    check("b2b_level1", bus.fifo_level, 1);
    push_word(32'hFFFFFFFF, 8'hFC);
    check("b2b_level2", bus.fifo_level, 2);
    wait_idle("t12_idle");
    check("active_after_busy", bus.tx_busy, 0);
    check("t12_all_sent", exp_q.size(), 0);
    check("t12_byte_count", starts - base, 18);

    // Stalled transmitter while in_valid is held for 6 words
    busy_len = 12;
    stall = 1'b1;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      if (k < 6) begin
        bus.in_valid = 1'b1;
        bus.in_data  = w3[k];
        if (bus.in_ready) begin
          exp_push(w3[k], c3[k]);
          k++;
        end
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("full_accepted", k, 5);
    check("full_level", bus.fifo_level, 4);
    check("full_in_ready", bus.in_ready, 0);
    check("full_active", bus.active, 1);
    stall = 1'b0;
    wait_idle("t3_idle");
    check("t3_all_sent", exp_q.size(), 0);

    // Push and pop in the same cycle at level 2
    stall = 1'b1;
    push_word(32'hA5A5A5A5, 8'h94);
    push_word(32'h00000001, 8'h01);
    push_word(32'h00000100, 8'h01);
    check("pp_level_pre", bus.fifo_level, 2);
    stall = 1'b0;
    n = 0;
    while (bus.active && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("pp_idle_seen", bus.active, 0);
    check("pp_level_idle", bus.fifo_level, 2);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h10203040;
    exp_push(32'h10203040, 8'hA0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("pp_level_post", bus.fifo_level, 2);
    check("pp_hdr_start", bus.tx_start, 1);
    wait_idle("t4_idle");
    check("t4_all_sent", exp_q.size(), 0);

    // Reset during WAIT_LO of the third byte
    base = starts;
    push_word(32'hCAFEBABE, 8'h40);
    n = 0;
    while (starts < base + 3 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("mid_third_byte", starts - base, 3);
    repeat (4) @(negedge clk);
    check("mid_inflight", bus.active, 1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_tx_start", bus.tx_start, 0);
    check("mid_rst_tx_data", bus.tx_data, 8'h00);
    check("mid_rst_active", bus.active, 0);
    check("mid_rst_level", bus.fifo_level, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = starts;
    push_word(32'h01020304, 8'h0A);
    wait_idle("t5_idle");
    check("t5_all_sent", exp_q.size(), 0);
    check("t5_byte_count", starts - base, 6);

    // Parameter sweep instances
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'hC3;
    exp1_q.push_back(8'h5A); exp1_q.push_back(8'hC3); exp1_q.push_back(8'hC3);
    bus8.in_valid = 1'b1;
    bus8.in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    exp8_q.push_back(8'hA5);
    for (int i = 0; i < 8; i++) exp8_q.push_back(8'hFF);
    exp8_q.push_back(8'hF8);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    bus8.in_valid = 1'b0;
    n = 0;
    while ((bus1.active || bus8.active || bus1.fifo_level != 0 || bus8.fifo_level != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("sweep1_count", n1, 3);
    check("sweep8_count", n8, 10);
    check("sweep1_all_sent", exp1_q.size(), 0);
    check("sweep8_all_sent", exp8_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
